// File: rtl/serial_subtractor_if.sv
// ============================================================================
// serial_subtractor_if : request/result bundle for the bit-serial subtractor.
// Optional signal ovf exists only when SERIAL_SUB_OVF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             zero;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, zero, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, zero, ovf
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, zero
   );
`endif

endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : diff = a - b, one bit per clock LSB first, single
// full-subtractor cell. Macro SERIAL_SUB_OVF_EN adds signed-overflow output.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input wire                  clk,
   input wire                  rst_n,
   serial_subtractor_if.slave  bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  res_q;
   logic              bin_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;
   logic [WIDTH-1:0]  diff_q;
   logic              borrow_q;
   logic              zero_q;
`ifdef SERIAL_SUB_OVF_EN
   logic              a_msb_q;
   logic              b_msb_q;
   logic              ovf_q;
`endif

   logic              bit_d;
   logic              bout_d;
   logic [WIDTH:0]    res_cat_d;
   logic [WIDTH-1:0]  res_d;
   logic              last_d;

   // Full-subtractor cell on the operand LSBs and the registered borrow
   always_comb begin
      bit_d     = a_q[0] ^ b_q[0] ^ bin_q;
      bout_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
      res_cat_d = {bit_d, res_q};
      res_d     = res_cat_d[WIDTH:1];
      last_d    = (cnt_q == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         bin_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  res_q   <= '0;
                  bin_q   <= 1'b0;
                  cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb_q <= bus.a[WIDTH-1];
                  b_msb_q <= bus.b[WIDTH-1];
`endif
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= res_d;
               bin_q <= bout_d;
               cnt_q <= cnt_q + CNT_W'(1);
               // Results are captured from the final cell outputs, never partials
               if (last_d) begin
                  diff_q   <= res_d;
                  borrow_q <= bout_d;
                  zero_q   <= (res_d == '0);
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q    <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
   assign bus.zero       = zero_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf        = ovf_q;
`endif

endmodule

`default_nettype wire
